temp_bcd_formatter: RTL and testbench

//  Consumes raw ADT7420 temperature words read over I2C by the temperature-polling controller and

---
 rtl/temp_bcd_formatter.sv | 170 +++++++++++++++++
 tb/tb_temp_bcd_formatter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_bcd_formatter.sv
// temp_bcd_formatter
//   Converts a raw ADT7420 temperature word into a signed decimal display
//   word for the seven-segment driver. Integer degrees are converted with a
//   sequential double-dabble (one shift per clock, nine shifts). The result
//   appears ten clocks after the accepting edge.
//   Optional build macro TEMP_FRAC_EN: when defined, a tenths digit is
//   produced and the decimal point after the ones digit is enabled. When it
//   is undefined the tenths logic is not built.
module temp_bcd_formatter #(
    parameter bit TEMP_RES16 = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] raw_temp,
    output logic        busy,
    output logic        out_valid,
    output logic [19:0] disp_data,
    output logic [4:0]  dp_mask,
    output logic        neg
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [8:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic        sign_q, sign_d;
    logic        out_valid_q, out_valid_d;
    logic [19:0] disp_q, disp_d;
    logic [4:0]  dp_q, dp_d;
    logic        neg_q, neg_d;

    logic [15:0] norm;
    logic [15:0] mag;
    logic [11:0] bcd_adj;
    logic [15:0] low_digits;
    logic [4:0]  dp_value;

    // Everything is in 1/128 C units. The magnitude fits 16 bits unsigned:
    // negating 0x8000 wraps back to 0x8000, which reads as 32768.
    assign norm = TEMP_RES16 ? raw_temp : {raw_temp[15:3], 3'b000};
    assign mag  = norm[15] ? (~norm + 16'd1) : norm;

    // Add-3 correction of each BCD nibble ahead of the shift
    function automatic logic [11:0] dd_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign bcd_adj = dd_adjust(bcd_q);

`ifdef TEMP_FRAC_EN
    logic [3:0] tenths_q, tenths_d;
    logic [3:0] tenths_new;

    // Tenths digit: (frac7 * 10) >> 7, truncated, always 0..9
    assign tenths_new = 4'(({4'b0000, mag[6:0]} * 11'd10) >> 7);
    assign low_digits = {bcd_q, tenths_q};
    assign dp_value   = 5'b00010;

    // Tenths digit is held for the whole conversion
    always_ff @(posedge clk) begin
        if (rst) begin
            tenths_q <= 4'd0;
        end else begin
            tenths_q <= tenths_d;
        end
    end

    // Capture the tenths digit only when a reading is accepted
    always_comb begin
        tenths_d = tenths_q;
        if (state_q == S_IDLE && in_valid) begin
            tenths_d = tenths_new;
        end
    end
`else
    logic [6:0] unused_frac;

    assign unused_frac = mag[6:0];
    assign low_digits  = {4'h0, bcd_q};
    assign dp_value    = 5'b00000;
`endif

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            bin_q       <= 9'd0;
            bcd_q       <= 12'd0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            disp_q      <= 20'd0;
            dp_q        <= 5'd0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            disp_q      <= disp_d;
            dp_q        <= dp_d;
            neg_q       <= neg_d;
        end
    end

    // Next-state: accept in IDLE, nine double-dabble shifts in CONV, publish in DONE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        sign_d      = sign_q;
        out_valid_d = 1'b0;
        disp_d      = disp_q;
        dp_d        = dp_q;
        neg_d       = neg_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = norm[15];
                    bin_d   = mag[15:7];
                    bcd_d   = 12'd0;
                    cnt_d   = 4'd9;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d = {bcd_adj[10:0], bin_q[8]};
                bin_d = {bin_q[7:0], 1'b0};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                disp_d      = {(sign_q ? 4'hF : 4'h0), low_digits};
                dp_d        = dp_value;
                neg_d       = sign_q;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign disp_data = disp_q;
    assign dp_mask   = dp_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_temp_bcd_formatter.sv
// Bench for temp_bcd_formatter: two instances (16-bit and 13-bit raw modes)
// share one stimulus stream; expected results are queued at issue time and
// popped by per-instance monitors whenever out_valid is seen.
module tb_temp_bcd_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] raw_temp;

    logic        busy16, ov16, neg16;
    logic [19:0] disp16;
    logic [4:0]  dp16;
    logic        busy13, ov13, neg13;
    logic [19:0] disp13;
    logic [4:0]  dp13;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [19:0] disp;
        logic [4:0]  dp;
        logic        neg;
        int          acc;
    } exp_t;

    exp_t q16[$];
    exp_t q13[$];

    typedef struct {
        logic [15:0] raw;
        logic [19:0] f16;
        logic [19:0] f13;
        logic [19:0] nf;
    } vec_t;

    // raw, frac 16-bit mode, frac 13-bit mode, integer-only build
    vec_t vecs[13] = '{
        '{16'h0C80, 20'h00250, 20'h00250, 20'h00025},
        '{16'hF380, 20'hF0250, 20'hF0250, 20'hF0025},
        '{16'h0CC0, 20'h00255, 20'h00255, 20'h00025},
        '{16'h7FFF, 20'h02559, 20'h02559, 20'h00255},
        '{16'h8000, 20'hF2560, 20'hF2560, 20'hF0256},
        '{16'h0000, 20'h00000, 20'h00000, 20'h00000},
        '{16'hFFFF, 20'hF0000, 20'hF0000, 20'hF0000},
        '{16'h0C87, 20'h00250, 20'h00250, 20'h00025},
        '{16'h0C8F, 20'h00251, 20'h00250, 20'h00025},
        '{16'hFF80, 20'hF0010, 20'hF0010, 20'hF0001},
        '{16'h00C0, 20'h00015, 20'h00015, 20'h00001},
        '{16'h3200, 20'h01000, 20'h01000, 20'h00100},
        '{16'h31F0, 20'h00998, 20'h00998, 20'h00099}
    };

`ifdef TEMP_FRAC_EN
    localparam logic [4:0] EXP_DP = 5'b00010;
`else
    localparam logic [4:0] EXP_DP = 5'b00000;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    temp_bcd_formatter u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .raw_temp  (raw_temp),
        .busy      (busy16),
        .out_valid (ov16),
        .disp_data (disp16),
        .dp_mask   (dp16),
        .neg       (neg16)
    );

    temp_bcd_formatter #(.TEMP_RES16(1'b0)) u_dut13 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .raw_temp  (raw_temp),
        .busy      (busy13),
        .out_valid (ov13),
        .disp_data (disp13),
        .dp_mask   (dp13),
        .neg       (neg13)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [19:0] d, input int acc);
        exp_t e;
        e.disp = d;
        e.dp   = EXP_DP;
        e.neg  = (d[19:16] == 4'hF);
        e.acc  = acc;
        return e;
    endfunction

    // Monitor for the 16-bit instance
    always @(negedge clk) begin
        if (ov16) begin
            if (q16.size() == 0) begin
                chk("res16_unexpected_out_valid", 32'(ov16), 32'd0);
            end else begin
                exp_t e;
                e = q16.pop_front();
                $display("txn res16 disp=0x%05h dp=%05b neg=%0b latency=%0d", disp16, dp16, neg16, cyc - e.acc);
                chk("res16_disp", 32'(disp16), 32'(e.disp));
                chk("res16_dp", 32'(dp16), 32'(e.dp));
                chk("res16_neg", 32'(neg16), 32'(e.neg));
                chk("res16_latency", 32'(cyc - e.acc), 32'd10);
            end
        end
    end

    // Monitor for the 13-bit instance
    always @(negedge clk) begin
        if (ov13) begin
            if (q13.size() == 0) begin
                chk("res13_unexpected_out_valid", 32'(ov13), 32'd0);
            end else begin
                exp_t e;
                e = q13.pop_front();
                $display("txn res13 disp=0x%05h dp=%05b neg=%0b latency=%0d", disp13, dp13, neg13, cyc - e.acc);
                chk("res13_disp", 32'(disp13), 32'(e.disp));
                chk("res13_dp", 32'(dp13), 32'(e.dp));
                chk("res13_neg", 32'(neg13), 32'(e.neg));
                chk("res13_latency", 32'(cyc - e.acc), 32'd10);
            end
        end
    end

    task automatic issue(input logic [15:0] raw, input logic [19:0] e16, input logic [19:0] e13);
        @(negedge clk);
        in_valid = 1'b1;
        raw_temp = raw;
        q16.push_back(mk_exp(e16, cyc + 1));
        q13.push_back(mk_exp(e13, cyc + 1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_after_accept", 32'(busy16), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q16.size() != 0 || q13.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (q16.size() != 0 || q13.size() != 0) begin
            chk("drain_timeout", 32'(q16.size() + q13.size()), 32'd0);
            q16.delete();
            q13.delete();
        end
        @(negedge clk);
        chk("busy_after_done", 32'(busy16), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        raw_temp = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 32'(busy16), 32'd0);
        chk("reset_out_valid", 32'(ov16), 32'd0);
        chk("reset_disp", 32'(disp16), 32'd0);
        chk("reset_dp", 32'(dp16), 32'd0);
        chk("reset_neg", 32'(neg16), 32'd0);

        // Directed conversions
        foreach (vecs[i]) begin
`ifdef TEMP_FRAC_EN
            issue(vecs[i].raw, vecs[i].f16, vecs[i].f13);
`else
            issue(vecs[i].raw, vecs[i].nf, vecs[i].nf);
`endif
            drain();
        end

        // Outputs hold the last result between conversions
        repeat (5) @(negedge clk);
`ifdef TEMP_FRAC_EN
        chk("hold_disp", 32'(disp16), 32'h00998);
`else
        chk("hold_disp", 32'(disp16), 32'h00099);
`endif

        // A reading offered while busy is dropped: one 25 C pulse only
        @(negedge clk);
        in_valid = 1'b1;
        raw_temp = 16'h0C80;
`ifdef TEMP_FRAC_EN
        q16.push_back(mk_exp(20'h00250, cyc + 1));
        q13.push_back(mk_exp(20'h00250, cyc + 1));
`else
        q16.push_back(mk_exp(20'h00025, cyc + 1));
        q13.push_back(mk_exp(20'h00025, cyc + 1));
`endif
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        raw_temp = 16'h1900;
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        repeat (15) @(negedge clk);

        // Reset mid-conversion discards it and clears all outputs
        @(negedge clk);
        in_valid = 1'b1;
        raw_temp = 16'h1900;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy16), 32'd0);
        chk("midrst_out_valid", 32'(ov16), 32'd0);
        chk("midrst_disp", 32'(disp16), 32'd0);
        chk("midrst_dp", 32'(dp16), 32'd0);
        chk("midrst_neg", 32'(neg16), 32'd0);
        chk("midrst_disp13", 32'(disp13), 32'd0);
        repeat (15) @(negedge clk);

        // Recovery after reset
`ifdef TEMP_FRAC_EN
        issue(16'h0CC0, 20'h00255, 20'h00255);
`else
        issue(16'h0CC0, 20'h00025, 20'h00025);
`endif
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
